// File: rtl/exception_ctrl.sv
// Exception controller for the pipelined LEGv8 core: latches and masks requests, takes the
// highest-priority one, redirects fetch to its vector and holds return state until ERET.
module exception_ctrl #(
   parameter int             N          = 64,
   parameter int             NSRC       = 4,
   parameter logic [N-1:0]   VEC_BASE   = 'hD8,
   parameter logic [N-1:0]   VEC_STRIDE = 'h20
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [NSRC-1:0] exc_req,
   input  logic [NSRC-1:0] exc_mask,
   input  logic [N-1:0]    imem_addr_F,
   input  logic [N-1:0]    NextPC_F,
   input  logic [N-1:0]    PCBranch_EX,
   input  logic            ERet,
   input  logic [1:0]      IM_readData,
   output logic            EProc,
   output logic            ExcAck,
   output logic            in_handler,
   output logic [N-1:0]    ExcVector,
   output logic [N-1:0]    PCBranch_EXP,
   output logic [N-1:0]    readData3_E
);
   localparam int CW = (NSRC > 1) ? $clog2(NSRC) : 1;

   typedef enum logic [1:0] {IDLE, REDIRECT, HANDLER} state_t;

   state_t          state_q;
   logic [NSRC-1:0] pending_q, pending_d;
   logic [NSRC-1:0] eligible;
   logic [NSRC-1:0] clearMask;
   logic [CW-1:0]   cause_q;
   logic [CW-1:0]   winner;
   logic [N-1:0]    elr_q, err_q, esr_q;

   // Fixed priority: scanning downward leaves the lowest eligible index as the winner.
   always_comb begin
      eligible = pending_q & ~exc_mask;
      winner   = '0;
      for (int i = NSRC - 1; i >= 0; i--) begin
         if (eligible[i]) winner = CW'(i);
      end
   end

   assign ExcVector  = VEC_BASE + N'(cause_q) * VEC_STRIDE;
   assign ExcAck     = (state_q == REDIRECT) && (imem_addr_F == ExcVector);
   assign EProc      = (state_q == REDIRECT);
   assign in_handler = (state_q == HANDLER);

   // A request arriving on the ack edge for the same source re-arms it, so OR-ing last wins.
   assign clearMask = ExcAck ? (NSRC'(1) << cause_q) : '0;
   assign pending_d = (pending_q & ~clearMask) | exc_req;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= IDLE;
         pending_q <= '0;
         cause_q   <= '0;
         elr_q     <= '0;
         err_q     <= '0;
         esr_q     <= '0;
      end else begin
         pending_q <= pending_d;
         case (state_q)
            IDLE: begin
               if (|eligible) begin
                  elr_q   <= imem_addr_F;
                  err_q   <= NextPC_F;
                  esr_q   <= N'(winner);
                  cause_q <= winner;
                  state_q <= REDIRECT;
               end
            end
            REDIRECT: begin
               if (ExcAck) state_q <= HANDLER;
            end
            HANDLER: begin
               if (ERet) state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign PCBranch_EXP = ((state_q == HANDLER) && ERet) ? err_q : PCBranch_EX;

   always_comb begin
      readData3_E = '0;
      case (IM_readData)
         2'd0:    readData3_E = err_q;
         2'd1:    readData3_E = elr_q;
         2'd2:    readData3_E = esr_q;
         default: readData3_E = N'(pending_q);
      endcase
   end

endmodule

// File: tb/tb_exception_ctrl.sv
// Bench for exception_ctrl: a directed vector table, hand-written mask/hold-off/reset
// sequences, then random traffic compared against a cycle-level behavioural model.
module tb_exception_ctrl;
   localparam int N    = 64;
   localparam int NSRC = 4;

   logic            clk = 1'b0;
   logic            reset;
   logic [NSRC-1:0] exc_req, exc_mask;
   logic [N-1:0]    imem_addr_F, NextPC_F, PCBranch_EX;
   logic            ERet;
   logic [1:0]      IM_readData;
   logic            EProc, ExcAck, in_handler;
   logic [N-1:0]    ExcVector, PCBranch_EXP, readData3_E;

   int nChecks = 0;
   int nPass   = 0;

   always #5 clk = ~clk;

   exception_ctrl #(.N(N), .NSRC(NSRC), .VEC_BASE(64'hD8), .VEC_STRIDE(64'h20)) dut (
      .clk(clk), .reset(reset), .exc_req(exc_req), .exc_mask(exc_mask),
      .imem_addr_F(imem_addr_F), .NextPC_F(NextPC_F), .PCBranch_EX(PCBranch_EX),
      .ERet(ERet), .IM_readData(IM_readData), .EProc(EProc), .ExcAck(ExcAck),
      .in_handler(in_handler), .ExcVector(ExcVector), .PCBranch_EXP(PCBranch_EXP),
      .readData3_E(readData3_E)
   );

   typedef struct {
      logic [3:0]  req, mask;
      logic [63:0] addr, npc;
      logic        eret;
      logic [1:0]  sel;
      logic [63:0] pcb;
      logic        eEProc, eAck, eInH;
      logic [63:0] eVec, eRd, ePcb;
   } vec_t;

   vec_t vecs[17];

   function automatic vec_t mkVec(input logic [3:0] req, input logic [63:0] addr, npc,
                                  input logic eret, input logic [1:0] sel, input logic [63:0] pcb,
                                  input logic eEProc, eAck, eInH,
                                  input logic [63:0] eVec, eRd, ePcb);
      vec_t v;
      v.req = req; v.mask = 4'b0; v.addr = addr; v.npc = npc; v.eret = eret; v.sel = sel;
      v.pcb = pcb; v.eEProc = eEProc; v.eAck = eAck; v.eInH = eInH;
      v.eVec = eVec; v.eRd = eRd; v.ePcb = ePcb;
      return v;
   endfunction

   task automatic applyStimulus(input logic [3:0] req, mask, input logic [63:0] addr, npc,
                                input logic eret, input logic [1:0] sel, input logic [63:0] pcb);
      exc_req = req; exc_mask = mask; imem_addr_F = addr; NextPC_F = npc;
      ERet = eret; IM_readData = sel; PCBranch_EX = pcb;
   endtask

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      nChecks++;
      if (act === exp) nPass++;
      else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   task automatic stepClock();
      @(posedge clk);
      #1;
   endtask

   // Behavioural reference state for the random phase
   int          mMode;
   int          mCause;
   logic [3:0]  mPend;
   logic [63:0] mElr, mErr, mEsr;

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      reset = 1'b1;
      applyStimulus(4'b0, 4'b0, 64'h0, 64'h0, 1'b0, 2'd0, 64'h0);
      #2;
      checkOutput("reset EProc", EProc, 1'b0);
      checkOutput("reset ExcVector", ExcVector, 64'hD8);
      #11 reset = 1'b0;
      stepClock();

      //          req  addr    npc     er sel pcb      EP Ak IH vec     rd      pcbExp
      vecs[0]  = mkVec(4'h4, 64'h10,  64'h14,  0, 3, 64'h500, 0, 0, 0, 64'hD8,  64'h0,   64'h500);
      vecs[1]  = mkVec(4'h0, 64'h40,  64'h44,  0, 3, 64'h500, 0, 0, 0, 64'hD8,  64'h4,   64'h500);
      vecs[2]  = mkVec(4'h0, 64'h100, 64'h104, 0, 1, 64'h500, 1, 0, 0, 64'h118, 64'h40,  64'h500);
      vecs[3]  = mkVec(4'h0, 64'h100, 64'h104, 0, 0, 64'h500, 1, 0, 0, 64'h118, 64'h44,  64'h500);
      vecs[4]  = mkVec(4'h0, 64'h118, 64'h11C, 0, 2, 64'h500, 1, 1, 0, 64'h118, 64'h2,   64'h500);
      vecs[5]  = mkVec(4'h0, 64'h11C, 64'h120, 0, 3, 64'h500, 0, 0, 1, 64'h118, 64'h0,   64'h500);
      vecs[6]  = mkVec(4'h0, 64'h120, 64'h124, 1, 0, 64'h500, 0, 0, 1, 64'h118, 64'h44,  64'h44);
      vecs[7]  = mkVec(4'h0, 64'h44,  64'h48,  1, 3, 64'h500, 0, 0, 0, 64'h118, 64'h0,   64'h500);
      vecs[8]  = mkVec(4'hA, 64'h200, 64'h204, 0, 3, 64'h600, 0, 0, 0, 64'h118, 64'h0,   64'h600);
      vecs[9]  = mkVec(4'h0, 64'h300, 64'h304, 0, 3, 64'h600, 0, 0, 0, 64'h118, 64'hA,   64'h600);
      vecs[10] = mkVec(4'h0, 64'hF8,  64'hFC,  0, 2, 64'h600, 1, 1, 0, 64'hF8,  64'h1,   64'h600);
      vecs[11] = mkVec(4'h0, 64'hFC,  64'h100, 0, 3, 64'h600, 0, 0, 1, 64'hF8,  64'h8,   64'h600);
      vecs[12] = mkVec(4'h0, 64'h100, 64'h104, 1, 0, 64'h600, 0, 0, 1, 64'hF8,  64'h304, 64'h304);
      vecs[13] = mkVec(4'h0, 64'h400, 64'h404, 0, 3, 64'h600, 0, 0, 0, 64'hF8,  64'h8,   64'h600);
      vecs[14] = mkVec(4'h0, 64'h138, 64'h13C, 0, 1, 64'h600, 1, 1, 0, 64'h138, 64'h400, 64'h600);
      vecs[15] = mkVec(4'h0, 64'h13C, 64'h140, 1, 3, 64'h600, 0, 0, 1, 64'h138, 64'h0,   64'h404);
      vecs[16] = mkVec(4'h0, 64'h404, 64'h408, 0, 2, 64'h600, 0, 0, 0, 64'h138, 64'h3,   64'h600);

      for (int i = 0; i < 17; i++) begin
         applyStimulus(vecs[i].req, vecs[i].mask, vecs[i].addr, vecs[i].npc,
                       vecs[i].eret, vecs[i].sel, vecs[i].pcb);
         #3;
         checkOutput($sformatf("row%0d EProc", i), EProc, vecs[i].eEProc);
         checkOutput($sformatf("row%0d ExcAck", i), ExcAck, vecs[i].eAck);
         checkOutput($sformatf("row%0d in_handler", i), in_handler, vecs[i].eInH);
         checkOutput($sformatf("row%0d ExcVector", i), ExcVector, vecs[i].eVec);
         checkOutput($sformatf("row%0d readData3_E", i), readData3_E, vecs[i].eRd);
         checkOutput($sformatf("row%0d PCBranch_EXP", i), PCBranch_EXP, vecs[i].ePcb);
         stepClock();
      end

      // Masked source stays pending and is taken one cycle after the mask clears
      applyStimulus(4'h1, 4'h1, 64'h500, 64'h504, 1'b0, 2'd3, 64'h0);
      #3 checkOutput("mask c0 EProc", EProc, 1'b0);
      stepClock();
      applyStimulus(4'h0, 4'h1, 64'h500, 64'h504, 1'b0, 2'd3, 64'h0);
      #3 checkOutput("mask c1 EProc", EProc, 1'b0);
      checkOutput("mask c1 pending", readData3_E, 64'h1);
      stepClock();
      #3 checkOutput("mask c2 EProc", EProc, 1'b0);
      stepClock();
      applyStimulus(4'h0, 4'h0, 64'h600, 64'h604, 1'b0, 2'd1, 64'h0);
      #3 checkOutput("unmask c3 EProc", EProc, 1'b0);
      stepClock();
      applyStimulus(4'h0, 4'h0, 64'hD8, 64'hDC, 1'b0, 2'd1, 64'h0);
      #3 checkOutput("unmask c4 EProc", EProc, 1'b1);
      checkOutput("unmask c4 ExcVector", ExcVector, 64'hD8);
      checkOutput("unmask c4 ELR", readData3_E, 64'h600);
      checkOutput("unmask c4 ExcAck", ExcAck, 1'b1);
      stepClock();

      // Hold-off: a request inside the handler waits for ERET
      applyStimulus(4'h1, 4'h0, 64'hDC, 64'hE0, 1'b0, 2'd3, 64'h0);
      #3 checkOutput("hold c5 in_handler", in_handler, 1'b1);
      stepClock();
      applyStimulus(4'h0, 4'h0, 64'hE0, 64'hE4, 1'b0, 2'd3, 64'h0);
      #3 checkOutput("hold c6 pending", readData3_E, 64'h1);
      checkOutput("hold c6 EProc", EProc, 1'b0);
      stepClock();
      applyStimulus(4'h0, 4'h0, 64'hE4, 64'hE8, 1'b1, 2'd3, 64'h0);
      #3 checkOutput("hold c7 EProc", EProc, 1'b0);
      checkOutput("hold c7 in_handler", in_handler, 1'b1);
      stepClock();
      applyStimulus(4'h0, 4'h0, 64'h700, 64'h704, 1'b0, 2'd0, 64'h0);
      #3 checkOutput("hold c8 EProc", EProc, 1'b0);
      checkOutput("hold c8 in_handler", in_handler, 1'b0);
      stepClock();
      #3 checkOutput("hold c9 EProc", EProc, 1'b1);
      checkOutput("hold c9 ERR", readData3_E, 64'h704);

      // Asynchronous reset in the middle of REDIRECT, with a request present
      #1 reset = 1'b1;
      exc_req = 4'hF;
      #1 checkOutput("rst EProc", EProc, 1'b0);
      checkOutput("rst in_handler", in_handler, 1'b0);
      checkOutput("rst ExcVector", ExcVector, 64'hD8);
      for (int s = 0; s < 4; s++) begin
         IM_readData = 2'(s);
         #1 checkOutput($sformatf("rst readData3_E sel%0d", s), readData3_E, 64'h0);
      end
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      exc_req = 4'h0;
      IM_readData = 2'd3;
      stepClock();
      #3 checkOutput("post-rst pending", readData3_E, 64'h0);
      checkOutput("post-rst EProc", EProc, 1'b0);

      // Random traffic against the behavioural model, starting from the clean post-reset state
      mMode = 0; mCause = 0; mPend = 4'b0; mElr = '0; mErr = '0; mEsr = '0;
      for (int k = 0; k < 400; k++) begin
         logic [3:0]  rq, mk;
         logic [63:0] ad, np, pb, eVec, eRd, ePcb;
         logic        er, eAck;
         logic [1:0]  sl;
         int          win;
         rq   = ($urandom_range(0, 5) == 0) ? 4'($urandom) : 4'b0;
         mk   = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0;
         eVec = 64'hD8 + 64'(mCause) * 64'h20;
         ad   = (mMode == 1 && $urandom_range(0, 2) == 0) ? eVec : {32'b0, $urandom};
         np   = ad + 64'd4;
         pb   = {32'b0, $urandom};
         er   = ($urandom_range(0, 3) == 0);
         sl   = 2'($urandom);
         applyStimulus(rq, mk, ad, np, er, sl, pb);
         eAck = (mMode == 1) && (ad == eVec);
         ePcb = (mMode == 2 && er) ? mErr : pb;
         case (sl)
            2'd0:    eRd = mErr;
            2'd1:    eRd = mElr;
            2'd2:    eRd = mEsr;
            default: eRd = {60'b0, mPend};
         endcase
         #3;
         checkOutput("rnd EProc", EProc, (mMode == 1));
         checkOutput("rnd ExcAck", ExcAck, eAck);
         checkOutput("rnd in_handler", in_handler, (mMode == 2));
         checkOutput("rnd ExcVector", ExcVector, eVec);
         checkOutput("rnd PCBranch_EXP", PCBranch_EXP, ePcb);
         checkOutput("rnd readData3_E", readData3_E, eRd);
         win = -1;
         for (int s = 0; s < 4; s++) begin
            if (mPend[s] && !mk[s] && win < 0) win = s;
         end
         if (eAck) mPend[mCause] = 1'b0;
         mPend = mPend | rq;
         if (mMode == 0 && win >= 0) begin
            mElr = ad; mErr = np; mEsr = 64'(win); mCause = win; mMode = 1;
         end else if (mMode == 1 && eAck) begin
            mMode = 2;
         end else if (mMode == 2 && er) begin
            mMode = 0;
         end
         stepClock();
      end

      $display("%0d/%0d checks passed", nPass, nChecks);
      $finish;
   end

endmodule
